// File: rtl/ram_test_pkg.sv
// Shared definitions for the RAM test engine configuration slave.
// Holds the register offsets, the CFG field layout and the AXI write
// response encodings used by the slave and its write-holding sub-module.
package ram_test_pkg;

  localparam logic [7:0] REG_CFG     = 8'h00;
  localparam logic [7:0] REG_BASE    = 8'h04;
  localparam logic [7:0] REG_END     = 8'h08;
  localparam logic [7:0] REG_STS     = 8'h0C;
  localparam logic [7:0] REG_CURRENT = 8'h10;
  localparam logic [7:0] REG_WRITE   = 8'h14;
  localparam logic [7:0] REG_TIME    = 8'h18;
  localparam logic [7:0] REG_ERRORS  = 8'h1C;
  localparam logic [7:0] REG_LAST    = 8'h20;

  localparam int CFG_BURST_LSB     = 28;
  localparam int CFG_BURST_W       = 4;
  localparam int CFG_READ_BIT      = 8;
  localparam int CFG_RND_DELAY_BIT = 7;
  localparam int CFG_USER_BIT      = 3;
  localparam int CFG_INCR_BIT      = 2;
  localparam int CFG_ONES_BIT      = 1;
  localparam int CFG_ZERO_BIT      = 0;

  // Cycles a start request stays pending while the engine has not yet
  // reported busy.
  localparam int START_TIMEOUT = 4;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  // Implemented CFG bits; everything else is forced to zero.
  function automatic logic [31:0] cfg_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < CFG_BURST_W; i++) m[CFG_BURST_LSB + i] = 1'b1;
    m[CFG_READ_BIT]      = 1'b1;
    m[CFG_RND_DELAY_BIT] = 1'b1;
    m[CFG_USER_BIT]      = 1'b1;
    m[CFG_INCR_BIT]      = 1'b1;
    m[CFG_ONES_BIT]      = 1'b1;
    m[CFG_ZERO_BIT]      = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axil_wr_hold.sv
// AXI4-Lite write-side front end: accepts AW and W independently into
// 1-deep holding registers, signals a commit in the cycle both are held,
// then raises BVALID with the response chosen by the register bank.
// Ports: clk_i/rst_ni, AW/W/B handshakes, commit_resp (response for the
// write being committed), commit strobe plus held address/data/strobes.
module axil_wr_hold
  import ram_test_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        awvalid,
  input  logic [7:0]  awaddr,
  output logic        awready,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        wready,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  resp_e       commit_resp,
  output logic        commit,
  output logic [7:0]  commit_addr,
  output logic [31:0] commit_data,
  output logic [3:0]  commit_strb
);

  logic        aw_held;
  logic        w_held;
  logic [7:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic        bvalid_q;
  resp_e       bresp_q;

  // Readies are gated by reset so nothing is accepted while held in reset.
  assign awready     = rst_ni && !aw_held && !bvalid_q;
  assign wready      = rst_ni && !w_held && !bvalid_q;
  assign commit      = aw_held && w_held;
  assign commit_addr = aw_addr_q;
  assign commit_data = w_data_q;
  assign commit_strb = w_strb_q;
  assign bvalid      = bvalid_q;
  assign bresp       = bresp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else if (commit) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b1;
      bresp_q  <= commit_resp;
    end else begin
      if (awvalid && awready) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (bvalid_q && bready) bvalid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_test_cfg_slave.sv
// AXI4-Lite configuration/status register bank for the RAM test engine.
// Holds CFG/BASE/END/WRITE, pulses start_o on an accepted CFG write and
// returns live engine status on reads.
// Ports: clk_i/rst_ni, AXI-Lite cfg_* write and read channels, engine
// status inputs (busy_i, current_i, cycles_i, errors_i, last_rd_i),
// register outputs (cfg_o, base_o, end_o, pattern_o) and start_o.
module ram_test_cfg_slave
  import ram_test_pkg::*;
#(
  parameter logic [31:0] BASE_RESET  = 32'h0,
  parameter logic [31:0] END_RESET   = 32'h0,
  parameter logic [31:0] WRITE_RESET = 32'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_awvalid_i,
  output logic        cfg_awready_o,
  input  logic [31:0] cfg_awaddr_i,
  input  logic        cfg_wvalid_i,
  output logic        cfg_wready_o,
  input  logic [31:0] cfg_wdata_i,
  input  logic [3:0]  cfg_wstrb_i,
  output logic        cfg_bvalid_o,
  input  logic        cfg_bready_i,
  output logic [1:0]  cfg_bresp_o,
  input  logic        cfg_arvalid_i,
  output logic        cfg_arready_o,
  input  logic [31:0] cfg_araddr_i,
  output logic        cfg_rvalid_o,
  input  logic        cfg_rready_i,
  output logic [31:0] cfg_rdata_o,
  output logic [1:0]  cfg_rresp_o,
  input  logic        busy_i,
  input  logic [31:0] current_i,
  input  logic [31:0] cycles_i,
  input  logic [31:0] errors_i,
  input  logic [31:0] last_rd_i,
  output logic [31:0] cfg_o,
  output logic [31:0] base_o,
  output logic [31:0] end_o,
  output logic [31:0] pattern_o,
  output logic        start_o
);

  localparam logic [31:0] CFG_MASK = cfg_mask();

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  logic        commit;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  resp_e       commit_resp;

  logic [31:0] cfg_q, base_q, end_q, pattern_q;
  logic        start_q, start_pending;
  logic [1:0]  pend_cnt;
  logic        rvalid_q;
  logic [31:0] rdata_q, rd_mux;
  logic        cfg_wr_hit, cfg_blocked;
  logic        unused_addr;

  assign unused_addr = ^{cfg_awaddr_i[31:8], cfg_araddr_i[31:8]};

  axil_wr_hold u_wr_hold (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .awvalid     (cfg_awvalid_i),
    .awaddr      (cfg_awaddr_i[7:0]),
    .awready     (cfg_awready_o),
    .wvalid      (cfg_wvalid_i),
    .wdata       (cfg_wdata_i),
    .wstrb       (cfg_wstrb_i),
    .wready      (cfg_wready_o),
    .bvalid      (cfg_bvalid_o),
    .bready      (cfg_bready_i),
    .bresp       (cfg_bresp_o),
    .commit_resp (commit_resp),
    .commit      (commit),
    .commit_addr (wr_addr),
    .commit_data (wr_data),
    .commit_strb (wr_strb)
  );

  // A CFG write with no strobes is a no-op and never starts the engine.
  assign cfg_wr_hit  = commit && (wr_addr == REG_CFG) && (wr_strb != 4'b0);
  assign cfg_blocked = busy_i || start_pending;
  assign commit_resp = (cfg_wr_hit && cfg_blocked) ? RESP_SLVERR : RESP_OKAY;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q     <= '0;
      base_q    <= BASE_RESET;
      end_q     <= END_RESET;
      pattern_q <= WRITE_RESET;
    end else if (commit && wr_strb != 4'b0) begin
      case (wr_addr)
        REG_CFG:   if (!cfg_blocked) cfg_q <= byte_merge(cfg_q, wr_data, wr_strb) & CFG_MASK;
        REG_BASE:  base_q    <= byte_merge(base_q, wr_data, wr_strb);
        REG_END:   end_q     <= byte_merge(end_q, wr_data, wr_strb);
        REG_WRITE: pattern_q <= byte_merge(pattern_q, wr_data, wr_strb);
        default:   ;
      endcase
    end
  end

  // Start handshake: pending covers the gap until the engine reports busy,
  // and gives up after START_TIMEOUT cycles if it never does.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q       <= 1'b0;
      start_pending <= 1'b0;
      pend_cnt      <= '0;
    end else begin
      start_q <= cfg_wr_hit && !cfg_blocked;
      if (cfg_wr_hit && !cfg_blocked) begin
        start_pending <= 1'b1;
        pend_cnt      <= '0;
      end else if (start_pending) begin
        if (busy_i || pend_cnt == 2'(START_TIMEOUT - 1)) start_pending <= 1'b0;
        else pend_cnt <= pend_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (cfg_araddr_i[7:0])
      REG_CFG:     rd_mux = cfg_q;
      REG_BASE:    rd_mux = base_q;
      REG_END:     rd_mux = end_q;
      REG_STS:     rd_mux = {31'b0, busy_i | start_pending};
      REG_CURRENT: rd_mux = current_i;
      REG_WRITE:   rd_mux = pattern_q;
      REG_TIME:    rd_mux = cycles_i;
      REG_ERRORS:  rd_mux = errors_i;
      REG_LAST:    rd_mux = last_rd_i;
      default:     rd_mux = '0;
    endcase
  end

  assign cfg_arready_o = rst_ni && !rvalid_q;

  // Read data is captured at AR accept, so a same-cycle write commit to the
  // same register is not yet visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (cfg_arvalid_i && cfg_arready_o) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (rvalid_q && cfg_rready_i) begin
      rvalid_q <= 1'b0;
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;
  assign cfg_rresp_o  = RESP_OKAY;
  assign cfg_o        = cfg_q;
  assign base_o       = base_q;
  assign end_o        = end_q;
  assign pattern_o    = pattern_q;
  assign start_o      = start_q;

endmodule

// File: tb/tb_ram_test_cfg_slave.sv
// Directed bench for ram_test_cfg_slave: register reset values, write
// channel timing, CFG start/pending behaviour, byte strobes, B back-pressure
// and status reads.
module tb_ram_test_cfg_slave;

  localparam logic [31:0] BASE_RST  = 32'h1000_0000;
  localparam logic [31:0] END_RST   = 32'h2000_0000;
  localparam logic [31:0] WRITE_RST = 32'h5A5A_A5A5;
  localparam logic [31:0] CUR_V  = 32'hC0C0_0010;
  localparam logic [31:0] TIME_V = 32'h0000_1818;
  localparam logic [31:0] ERR_V  = 32'hDEAD_0005;
  localparam logic [31:0] LAST_V = 32'h1A57_0020;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0, busy = 0, start;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0]  wstrb = 0;
  logic [1:0]  bresp, rresp;
  logic [31:0] current = CUR_V, cycles = TIME_V, errors = ERR_V, last_rd = LAST_V;
  logic [31:0] cfg_q, base_q, end_q, pattern_q;

  int n_checks = 0;
  int n_fail = 0;
  int start_cnt = 0;

  ram_test_cfg_slave #(
    .BASE_RESET (BASE_RST),
    .END_RESET  (END_RST),
    .WRITE_RESET(WRITE_RST)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_awvalid_i(awvalid), .cfg_awready_o(awready), .cfg_awaddr_i(awaddr),
    .cfg_wvalid_i(wvalid), .cfg_wready_o(wready), .cfg_wdata_i(wdata), .cfg_wstrb_i(wstrb),
    .cfg_bvalid_o(bvalid), .cfg_bready_i(bready), .cfg_bresp_o(bresp),
    .cfg_arvalid_i(arvalid), .cfg_arready_o(arready), .cfg_araddr_i(araddr),
    .cfg_rvalid_o(rvalid), .cfg_rready_i(rready), .cfg_rdata_o(rdata), .cfg_rresp_o(rresp),
    .busy_i(busy), .current_i(current), .cycles_i(cycles), .errors_i(errors), .last_rd_i(last_rd),
    .cfg_o(cfg_q), .base_o(base_q), .end_o(end_q), .pattern_o(pattern_q), .start_o(start)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (start) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done, w_done, aw_fire, w_fire, got;
    aw_done = 0; w_done = 0; got = 0;
    resp = 2'b11;
    awaddr = 32'(a); wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      tick();
      if (aw_fire) begin awvalid = 0; aw_done = 1; end
      if (w_fire)  begin wvalid = 0;  w_done = 1;  end
    end
    awvalid = 0; wvalid = 0;
    bready = 1;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin
        resp = bresp; got = 1;
        tick();
        break;
      end
      tick();
    end
    bready = 0;
    if (!got) check("bvalid_timeout", 32'(bvalid), 32'd1);
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    bit got;
    got = 0; d = '1; r = 2'b11;
    araddr = 32'(a); arvalid = 1;
    for (int i = 0; i < 20; i++) begin
      if (arready) begin tick(); break; end
      tick();
    end
    arvalid = 0;
    for (int i = 0; i < 20; i++) begin
      if (rvalid) begin
        d = rdata; r = rresp; got = 1;
        rready = 1; tick(); rready = 0;
        break;
      end
      tick();
    end
    if (!got) check("rvalid_timeout", 32'(rvalid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] rd;
  logic [1:0]  rr, br;
  int          sc;
  logic [7:0]  rst_addr [4] = '{8'h04, 8'h08, 8'h14, 8'h00};
  logic [31:0] rst_exp  [4] = '{BASE_RST, END_RST, WRITE_RST, 32'h0};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_start", 32'(start), 0);
    check("rst_cfg_o", cfg_q, 0);
    check("rst_base_o", base_q, BASE_RST);
    check("rst_end_o", end_q, END_RST);
    check("rst_pattern_o", pattern_q, WRITE_RST);
    rst_n = 1;
    tick();
    check("idle_awready", 32'(awready), 1);
    check("idle_arready", 32'(arready), 1);

    for (int i = 0; i < 4; i++) begin
      axi_read(rst_addr[i], rd, rr);
      check($sformatf("rst_read_%02h", rst_addr[i]), rd, rst_exp[i]);
      check("rst_read_rresp", 32'(rr), 0);
    end

    // AW+W same cycle to END
    awaddr = 32'h08; wdata = 32'h0800_0000; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    check("t2_awready", 32'(awready), 1);
    check("t2_wready", 32'(wready), 1);
    tick();
    awvalid = 0; wvalid = 0;
    check("t2_commit_bvalid", 32'(bvalid), 0);
    check("t2_commit_awready", 32'(awready), 0);
    tick();
    check("t2_bvalid", 32'(bvalid), 1);
    check("t2_bresp", 32'(bresp), 0);
    check("t2_end_o", end_q, 32'h0800_0000);
    bready = 1; tick(); bready = 0;
    check("t2_bvalid_clear", 32'(bvalid), 0);
    axi_read(8'h08, rd, rr);
    check("t2_readback", rd, 32'h0800_0000);

    // W first, AW three cycles later to CFG
    sc = start_cnt;
    wdata = 32'h3000_0004; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    check("t3_wready_held", 32'(wready), 0);
    tick(); tick();
    awaddr = 32'h00; awvalid = 1;
    tick();
    awvalid = 0;
    check("t3_commit_bvalid", 32'(bvalid), 0);
    check("t3_commit_start", 32'(start), 0);
    tick();
    check("t3_bvalid", 32'(bvalid), 1);
    check("t3_bresp", 32'(bresp), 0);
    check("t3_start", 32'(start), 1);
    check("t3_cfg_o", cfg_q, 32'h3000_0004);
    bready = 1; araddr = 32'h0C; arvalid = 1;
    tick();
    bready = 0; arvalid = 0;
    check("t3_start_one_cycle", 32'(start), 0);
    check("t3_sts_rvalid", 32'(rvalid), 1);
    check("t3_sts_pending", rdata, 1);
    rready = 1; busy = 1;
    tick();
    rready = 0; busy = 0; arvalid = 1;
    tick();
    arvalid = 0;
    check("t3_sts_after_busy", rdata, 0);
    rready = 1; tick(); rready = 0;
    check("t3_start_count", 32'(start_cnt - sc), 1);

    // Masked CFG write starts, a second one during pending is refused,
    // and pending times out without busy
    sc = start_cnt;
    axi_write(8'h00, 32'hFFFF_FFFF, 4'hF, br);
    check("t3b_bresp", 32'(br), 0);
    check("t3b_cfg_mask", cfg_q, 32'hF000_018F);
    axi_write(8'h00, 32'h1111_1111, 4'hF, br);
    check("t3b_pending_slverr", 32'(br), 2);
    check("t3b_cfg_kept", cfg_q, 32'hF000_018F);
    tick(); tick();
    axi_read(8'h0C, rd, rr);
    check("t3b_sts_timeout", rd, 0);
    check("t3b_start_count", 32'(start_cnt - sc), 1);

    // CFG write while busy
    sc = start_cnt;
    busy = 1;
    axi_write(8'h00, 32'h2000_0008, 4'hF, br);
    check("t4_busy_slverr", 32'(br), 2);
    check("t4_cfg_kept", cfg_q, 32'hF000_018F);
    axi_read(8'h0C, rd, rr);
    check("t4_sts_busy", rd, 1);
    busy = 0;
    axi_write(8'h00, 32'h5555_5555, 4'h0, br);
    check("t4_nostrb_okay", 32'(br), 0);
    check("t4_nostrb_cfg", cfg_q, 32'hF000_018F);
    check("t4_no_start", 32'(start_cnt - sc), 0);

    // Byte strobes on WRITE
    axi_write(8'h14, 32'h0, 4'hF, br);
    check("t5_clear_pattern", pattern_q, 0);
    axi_write(8'h14, 32'hAABB_CCDD, 4'b0010, br);
    check("t5_strb_bresp", 32'(br), 0);
    check("t5_strb_pattern", pattern_q, 32'h0000_CC00);
    axi_write(8'h10, 32'hFFFF_FFFF, 4'hF, br);
    check("t5_ro_bresp", 32'(br), 0);
    axi_read(8'h10, rd, rr);
    check("t5_ro_current", rd, CUR_V);

    // B back-pressure with a read in flight
    awaddr = 32'h04; wdata = 32'h1234_5678; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    tick();
    araddr = 32'h1C; arvalid = 1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t6_awready_%0d", k), 32'(awready), 0);
      check($sformatf("t6_wready_%0d", k), 32'(wready), 0);
      check($sformatf("t6_bvalid_%0d", k), 32'(bvalid), 1);
      check($sformatf("t6_bresp_%0d", k), 32'(bresp), 0);
      if (k == 1) begin
        check("t6_err_rvalid", 32'(rvalid), 1);
        check("t6_err_rdata", rdata, ERR_V);
        rready = 1;
      end
      tick();
      arvalid = 0;
      rready = 0;
    end
    check("t6_base_o", base_q, 32'h1234_5678);
    bready = 1; tick(); bready = 0;
    check("t6_bvalid_clear", 32'(bvalid), 0);

    axi_read(8'h3C, rd, rr);
    check("t6_unmapped_rdata", rd, 0);
    check("t6_unmapped_rresp", 32'(rr), 0);
    axi_read(8'h18, rd, rr);
    check("t6_time", rd, TIME_V);
    axi_read(8'h20, rd, rr);
    check("t6_last", rd, LAST_V);

    // Reset while AW is held abandons the transaction
    awaddr = 32'h04; awvalid = 1;
    tick();
    awvalid = 0;
    #2 rst_n = 0;
    #1;
    check("t7_rst_awready", 32'(awready), 0);
    check("t7_rst_base", base_q, BASE_RST);
    tick();
    rst_n = 1;
    wdata = 32'hFFFF_0000; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    tick(); tick();
    check("t7_no_commit_bvalid", 32'(bvalid), 0);
    check("t7_base_kept", base_q, BASE_RST);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_test_cfg_slave.md
Name: ram_test_cfg_slave

Overview:
AXI4-Lite responder for the RAM test engine's configuration/status register bank, i.e. the target end of the cfg_* write/read interface a test sequencer drives.
- Decodes the 8-bit register offset and holds the programmable registers (CFG, BASE, END, WRITE).
- Issues a one-cycle start pulse on every committed CFG write.
- Returns live engine status (STS, CURRENT, TIME, ERRORS, LAST) on reads.
- Sits between the AXI-Lite config port and the test engine datapath.

Parameters:
- BASE_RESET, 32'h0, reset value of BASE.ADDR
- END_RESET, 32'h0, reset value of END.ADDR
- WRITE_RESET, 32'h0, reset value of WRITE.PATTERN

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_awvalid_i/cfg_awready_o  in/out  1  AW handshake
- cfg_awaddr_i  in  32  write address; only bits [7:0] decoded
- cfg_wvalid_i/cfg_wready_o  in/out  1  W handshake
- cfg_wdata_i  in  32  write data
- cfg_wstrb_i  in  4  byte strobes
- cfg_bvalid_o/cfg_bready_i  out/in  1  B handshake
- cfg_bresp_o  out  2  write response, OKAY=0 or SLVERR=2
- cfg_arvalid_i/cfg_arready_o  in/out  1  AR handshake
- cfg_araddr_i  in  32  read address; bits [7:0] decoded
- cfg_rvalid_o/cfg_rready_i  out/in  1  R handshake
- cfg_rdata_o  out  32  read data
- cfg_rresp_o  out  2  always OKAY
- busy_i  in  1  engine running
- current_i, cycles_i, errors_i, last_rd_i  in  32 each  engine status values
- cfg_o, base_o, end_o, pattern_o  out  32 each  register contents
- start_o  out  1  one-cycle start pulse

Behaviour:
Register map:
- 0x00 CFG: burst_len[31:28], read[8], rnd_delay[7], user[3], incr[2], ones[1], zero[0]; all other bits read 0.
- 0x04 BASE, 0x08 END, 0x14 WRITE: read/write.
- 0x0C STS: bit0 = busy_i | start_pending; read-only.
- 0x10 CURRENT, 0x18 TIME, 0x1C ERRORS, 0x20 LAST: read-only.

Reset: all outputs and registers 0 except BASE/END/WRITE, which take their parameter values. All ready signals are low during reset.

Write channel:
- AW and W are accepted independently, each into a 1-deep holding register.
- cfg_awready_o = !aw_held && !cfg_bvalid_o; cfg_wready_o = !w_held && !cfg_bvalid_o.
- Commit occurs in the cycle both are held. Byte-lane merge per wstrb. bvalid rises the next cycle and both holds clear.
- AW+W in the same cycle: commit the next cycle, bvalid the cycle after. Back-to-back throughput is one write per 3 cycles with bready=1.
- cfg_bvalid_o holds until cfg_bready_i; bresp is stable while valid.

CFG write:
- If busy_i=0: the register is updated, start_pending is set, and start_o pulses exactly one cycle, the cycle after commit. start_pending clears on the first cycle busy_i is seen high, or after 4 cycles without busy.
- If busy_i=1 or start_pending=1: the write is dropped, bresp=SLVERR, no start pulse.

Other writes:
- Writes to read-only or unmapped offsets: ignored, bresp=OKAY.
- Writes with wstrb=0: no change, OKAY; a CFG write with wstrb=0 does not start the engine.

Read channel:
- cfg_arready_o = !cfg_rvalid_o.
- rdata is registered from the decode at AR accept. rvalid rises the next cycle and holds with stable data until rready.
- Unmapped offsets read 0 with OKAY.
- A read and a write committing in the same cycle to the same register: the read returns the pre-write value.

Reset asserted mid-transaction: the outstanding transaction is abandoned, and start_o and start_pending clear immediately (asynchronous).

Decomposition:
- Shared package ram_test_pkg holds:
  - the register offset constants;
  - the CFG field bit positions and widths;
  - the BRESP encodings.
- One natural sub-module, axil_wr_hold: the AW/W 1-deep holding and commit logic.
- Decode and the read mux stay in the top module.

Test Plan:
- Reset then read 0x04/0x08/0x14 -> BASE_RESET/END_RESET/WRITE_RESET; read 0x00 -> 0; all RRESP=OKAY.
- AW+W same cycle to 0x08, data 0x0800_0000, wstrb F -> bvalid 2 cycles later with OKAY; end_o=0x0800_0000; read back matches.
- W first, AW 3 cycles later to 0x00, data 0x3000_0004 -> commit one cycle after AW; start_o high exactly 1 cycle; STS bit0=1 until busy_i seen and then busy_i falls.
- CFG write while busy_i=1 -> bresp=SLVERR, cfg_o unchanged, no start_o.
- wstrb=4'b0010, data 0xAABBCCDD to 0x14 with pattern 0 -> pattern_o=0x0000_CC00.
- bready held low 5 cycles -> awready/wready stay low, bvalid/bresp stable; read of 0x1C during this returns errors_i. Read of 0x3C -> 0, OKAY.
